// File: rtl/bin_conv_pkg.sv
// Shared types and elaboration-time helpers for the binary convolution stage.
package bin_conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WIN,
    S_POP,
    S_WRITE,
    S_SLIDE,
    S_DONE
  } bin_conv_state_t;

  function automatic int out_dim(input int len, input int k, input int stride);
    return (len - k) / stride + 1;
  endfunction

  function automatic int cnt_width(input int kk);
    return $clog2(kk + 1);
  endfunction

  // True when an address bus of aw bits can reach the last output index.
  function automatic bit addr_width_ok(input int n_out, input int aw);
    return (longint'(n_out - 1) >> aw) == 0;
  endfunction

endpackage

// File: rtl/bin_conv_stage_xnor_popcount.sv
// Combinational XNOR of window against kernel followed by a balanced adder tree.
module xnor_popcount
  import bin_conv_pkg::*;
#(
  parameter int KK = 9,
  localparam int CNT_W = cnt_width(KK)
) (
  input  logic [KK-1:0]    win_i,
  input  logic [KK-1:0]    weight_i,
  output logic [CNT_W-1:0] count_o
);

  localparam int LVLS = $clog2(KK);
  localparam int P    = 1 << LVLS;

  logic [KK-1:0] match;
  assign match = ~(win_i ^ weight_i);

  genvar gl, gi;
  // Level 0 holds the match bits zero-padded to a power of two; each level halves.
  for (gl = 0; gl <= LVLS; gl++) begin : g_lvl
    localparam int N = P >> gl;
    logic [CNT_W-1:0] s [N];
    for (gi = 0; gi < N; gi++) begin : g_node
      if (gl == 0) begin : g_leaf
        if (gi < KK) begin : g_bit
          assign s[gi] = CNT_W'(match[gi]);
        end else begin : g_pad
          assign s[gi] = '0;
        end
      end else begin : g_add
        assign s[gi] = g_lvl[gl-1].s[2*gi] + g_lvl[gl-1].s[2*gi+1];
      end
    end
  end

  assign count_o = g_lvl[LVLS].s[0];

endmodule

// File: rtl/bin_conv_stage.sv
// Binary convolution stage: XNOR-popcount each upstream window against a latched
// kernel, threshold it, write one bit per window and request the next slide.
module bin_conv_stage
  import bin_conv_pkg::*;
#(
  parameter int KERNEL_SIZE    = 3,
  parameter int IMAGE_ROW_LEN  = 32,
  parameter int IMAGE_COL_LEN  = 32,
  parameter int STRIDE         = 1,
  parameter int OUT_ADDR_WIDTH = 10,
  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE,
  localparam int CNT_W = cnt_width(KK),
  localparam int N_OUT = out_dim(IMAGE_ROW_LEN, KERNEL_SIZE, STRIDE) *
                         out_dim(IMAGE_COL_LEN, KERNEL_SIZE, STRIDE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KK-1:0]             weight_in,
  input  logic [CNT_W-1:0]          threshold,
  input  logic [KK-1:0]             win_in,
  input  logic                      win_valid,
  output logic                      slide,
  output logic [OUT_ADDR_WIDTH-1:0] ram_w_addr,
  output logic                      ram_w_data,
  output logic                      ram_w_en,
  output logic [CNT_W-1:0]          pop_out,
  output logic                      busy,
  output logic                      done
);

  if (!addr_width_ok(N_OUT, OUT_ADDR_WIDTH)) begin : g_addr_check
    $error("bin_conv_stage: OUT_ADDR_WIDTH cannot address N_OUT outputs");
  end

  localparam logic [OUT_ADDR_WIDTH-1:0] LAST_ADDR = OUT_ADDR_WIDTH'(N_OUT - 1);

  bin_conv_state_t state_q, state_d;
  logic [KK-1:0]             weight_q, weight_d;
  logic [CNT_W-1:0]          thr_q, thr_d;
  logic [KK-1:0]             win_q, win_d;
  logic [CNT_W-1:0]          pop_q, pop_d;
  logic [OUT_ADDR_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                      valid_prev_q;
  logic                      busy_q, busy_d;
  logic                      slide_q, slide_d;
  logic                      done_q, done_d;
  logic                      wen_q, wen_d;
  logic [OUT_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                      wdata_q, wdata_d;
  logic [CNT_W-1:0]          pop_out_q, pop_out_d;

  logic [CNT_W-1:0] pop_count;
  logic             win_edge;

  xnor_popcount #(.KK(KK)) u_popcount (
    .win_i    (win_q),
    .weight_i (weight_q),
    .count_o  (pop_count)
  );

  // Edge detector runs in every state; edges outside WAIT_WIN are simply dropped.
  assign win_edge = win_valid & ~valid_prev_q;

  always_comb begin
    state_d   = state_q;
    weight_d  = weight_q;
    thr_d     = thr_q;
    win_d     = win_q;
    pop_d     = pop_q;
    out_cnt_d = out_cnt_q;
    busy_d    = busy_q;
    slide_d   = 1'b0;
    done_d    = 1'b0;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    pop_out_d = pop_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          weight_d  = weight_in;
          thr_d     = threshold;
          out_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = S_WAIT_WIN;
        end
      end
      S_WAIT_WIN: begin
        if (win_edge) begin
          win_d   = win_in;
          state_d = S_POP;
        end
      end
      S_POP: begin
        pop_d   = pop_count;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        wen_d     = 1'b1;
        waddr_d   = out_cnt_q;
        wdata_d   = (pop_q >= thr_q);
        pop_out_d = pop_q;
        if (out_cnt_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          out_cnt_d = out_cnt_q + OUT_ADDR_WIDTH'(1);
          state_d   = S_SLIDE;
        end
      end
      S_SLIDE: begin
        slide_d = 1'b1;
        state_d = S_WAIT_WIN;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      weight_q     <= '0;
      thr_q        <= '0;
      win_q        <= '0;
      pop_q        <= '0;
      out_cnt_q    <= '0;
      valid_prev_q <= 1'b0;
      busy_q       <= 1'b0;
      slide_q      <= 1'b0;
      done_q       <= 1'b0;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= 1'b0;
      pop_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      weight_q     <= weight_d;
      thr_q        <= thr_d;
      win_q        <= win_d;
      pop_q        <= pop_d;
      out_cnt_q    <= out_cnt_d;
      valid_prev_q <= win_valid;
      busy_q       <= busy_d;
      slide_q      <= slide_d;
      done_q       <= done_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      pop_out_q    <= pop_out_d;
    end
  end

  assign slide      = slide_q;
  assign ram_w_addr = waddr_q;
  assign ram_w_data = wdata_q;
  assign ram_w_en   = wen_q;
  assign pop_out    = pop_out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/bin_conv_stage.md
# bin_conv_stage

Binary-convolution stage that consumes the K×K binary window produced by the window-slide stage and turns each window into one output-feature-map bit. Each window is XNORed with a latched binary kernel and the matches are popcounted. The result is compared against a threshold and written to the output RAM. The block then issues a slide request to the upstream window stage. It repeats this for every window of the frame and pulses done after the last write.

## Interface
- KERNEL_SIZE, 3, window/kernel edge length K
- IMAGE_ROW_LEN, 32, input frame rows
- IMAGE_COL_LEN, 32, input frame columns
- STRIDE, 1, window stride
- OUT_ADDR_WIDTH, 10, output RAM address width; must hold N_OUT-1
- Derived:
  - KK = K*K
  - CNT_W = $clog2(KK+1)
  - N_OUT = ((IMAGE_ROW_LEN-K)/STRIDE+1) * ((IMAGE_COL_LEN-K)/STRIDE+1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  frame start; sampled only in IDLE
- weight_in  in  KK  binary kernel; latched on accepted start
- threshold  in  CNT_W  activation threshold; latched on accepted start
- win_in  in  KK  upstream window; bit i corresponds to window element i
- win_valid  in  1  upstream window valid; level signal, may stay high several cycles
- slide  out  1  one-cycle pulse requesting the next window
- ram_w_addr  out  OUT_ADDR_WIDTH  output RAM write address
- ram_w_data  out  1  output bit
- ram_w_en  out  1  one-cycle write strobe
- pop_out  out  CNT_W  popcount of the last written window (debug/next layer)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last write

## Operation
- States: IDLE, WAIT_WIN, POP, WRITE, SLIDE, DONE.
- IDLE:
  - On start=1: latch weight_in and threshold, clear out_cnt, set busy, go to WAIT_WIN.
  - start in any other state is ignored.
- WAIT_WIN:
  - A rising edge on win_valid (win_valid=1 and the previous-cycle sample =0) registers win_in, then the FSM goes to POP.
  - The edge detector runs in all states.
  - win_valid edges outside WAIT_WIN are discarded, not queued.
  - The first window is expected without a slide; upstream supplies it on pipeline fill.
- POP: register pop = popcount(~(win ^ weight)), range 0..KK. Go to WRITE.
- WRITE:
  - Drive ram_w_en=1, ram_w_addr=out_cnt, ram_w_data=(pop >= threshold), pop_out=pop.
  - If out_cnt==N_OUT-1, go to DONE; otherwise increment out_cnt and go to SLIDE.
- SLIDE: slide=1 for one cycle, then WAIT_WIN.
- DONE: done=1 for one cycle, clear busy, then IDLE.
- Arithmetic: unsigned compare.
  - threshold=0 always writes 1.
  - threshold>KK always writes 0.
- Addressing: out_cnt never wraps; the frame ends at N_OUT-1.
- Reset mid-operation: return to IDLE, clear counters and the edge detector, abort any pending write, drop latched weights.

## Timing
- Reset values: slide=0, ram_w_addr=0, ram_w_data=0, ram_w_en=0, pop_out=0, busy=0, done=0.
- busy goes high on the cycle after start is accepted.
- Window latency, for a win_valid rising edge sampled at edge t:
  - t+1: pop registered.
  - t+2: ram_w_en high.
  - t+3: slide high, or done high for the last window.
- ram_w_addr and ram_w_data are valid only while ram_w_en=1; they hold their value otherwise.
- Throughput is one window per slide round trip; upstream latency between slide and the next win_valid edge is unbounded.
- slide is never asserted after the last write. done and slide are mutually exclusive.

## Structure
- Package bin_conv_pkg holds:
  - the state enum typedef bin_conv_state_t;
  - functions out_dim(len,k,stride) and cnt_width(kk);
  - a parameter check on OUT_ADDR_WIDTH, elaboration error if too narrow.
- Sub-module xnor_popcount (parameter KK): combinational XNOR plus adder-tree popcount. The POP register sits in the parent.

## Test plan
- Matching window: weights all 1, threshold=9, one win_valid pulse of win_in all 1 → pop_out=9, ram_w_data=1, addr 0 at t+2, slide at t+3.
- Inverse window: weights 9'b101010101, win_in 9'b010101010, threshold=1 → pop_out=0, data 0. Repeat with threshold=0 → data 1.
- Held valid: win_valid held high for 4 cycles → exactly one write and one slide. A second edge in POP or WRITE produces no extra write.
- Full frame at defaults (32×32, K=3, STRIDE=1) → 900 writes at addresses 0..899, 899 slides, done one cycle after write 899, busy low afterward.
- Reset mid-frame: rst=0 during the write to addr 17 → all outputs 0 the next cycle. A restarted frame writes from addr 0.
- Ignored inputs: start while busy → no relatch of weights (verify with changed weight_in). win_valid edges in IDLE → no write.
